// File: rtl/adc_wave_capture_pkg.sv
// adc_wave_capture_pkg
//   Types shared by the waveform capture stage and the VGA waveform renderer.
//   - sample_t     : one 8-bit ADC sample
//   - cap_state_e  : capture state machine encoding
//   - is_crossing  : rising-edge trigger test (unsigned compare)
package adc_wave_capture_pkg;

    typedef logic [7:0] sample_t;

    typedef enum logic [1:0] {
        ST_PRE   = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } cap_state_e;

    // A level of zero can never be crossed because nothing is below it.
    function automatic logic is_crossing(input sample_t prev, input sample_t cur,
                                         input sample_t level);
        return (prev < level) && (cur >= level);
    endfunction

endpackage

// File: rtl/adc_wave_capture_dpram.sv
// wave_dpram
//   Simple dual-port sample RAM, 2^ADDR_W x 8.
//   Ports:
//     clk_i    : clock
//     rst_i    : async active-high reset, clears the read register only
//     we_i     : write enable
//     waddr_i  : write address
//     wdata_i  : write data
//     raddr_i  : read address
//     rdata_o  : registered read data (1-cycle latency, read-before-write)
module wave_dpram
    import adc_wave_capture_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  sample_t           wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output sample_t           rdata_o
);

    sample_t mem_q [2**ADDR_W];
    sample_t rdata_q;

    // Write port; the array itself carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_wave_capture.sv
// adc_wave_capture
//   Triggered waveform capture. Samples adc_data once per SAMPLE_DIV clocks,
//   stores a 2^DEPTH_LOG2 frame with PRETRIG samples ahead of the trigger and
//   freezes it for the renderer until rearm.
//   Ports:
//     clk, rst     : clock, async active-high reset
//     adc_data     : raw ADC reader output (asynchronous to the sample tick)
//     trig_level   : unsigned trigger threshold
//     trig_mode    : 0 = normal, 1 = auto (forced trigger after AUTO_TIMEOUT)
//     rearm        : one-cycle pulse starting a new capture
//     rd_addr      : logical index, 0 = oldest sample of the frame
//     rd_data      : sample at rd_addr, one clock later
//     frame_ready  : a complete frame is frozen
//     triggered    : 1 = real crossing, 0 = auto-forced
//   PRETRIG is expected to be at least 1 and below the buffer depth.
module adc_wave_capture
    import adc_wave_capture_pkg::*;
#(
    parameter int SAMPLE_DIV   = 1250,
    parameter int DEPTH_LOG2   = 9,
    parameter int PRETRIG      = 64,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            adc_data,
    input  logic [7:0]            trig_level,
    input  logic                  trig_mode,
    input  logic                  rearm,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  frame_ready,
    output logic                  triggered
);

    localparam int DEPTH   = 2**DEPTH_LOG2;
    localparam int POST_N  = DEPTH - PRETRIG - 1;
    localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_MAX = (AUTO_TIMEOUT > DEPTH) ? AUTO_TIMEOUT : DEPTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [DIV_W-1:0]      div_q;
    logic                  tick_s;
    sample_t               s1_q, s2_q, cur_q, prev_q;
    logic                  wr_ev_q;
    cap_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, base_q, base_d;
    logic                  frame_ready_q, frame_ready_d;
    logic                  triggered_q, triggered_d;
    logic                  we_s, cross_s, timeout_s;
    logic [DEPTH_LOG2-1:0] raddr_s;

    assign tick_s = (div_q == DIV_W'(SAMPLE_DIV - 1));

    // Sample-rate divider, input synchroniser and cur/prev sample pipeline.
    // The divider free-runs; rearm does not disturb the sampling cadence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            s1_q    <= 8'h00;
            s2_q    <= 8'h00;
            cur_q   <= 8'h00;
            prev_q  <= 8'h00;
            wr_ev_q <= 1'b0;
        end else begin
            div_q   <= tick_s ? '0 : div_q + DIV_W'(1);
            s1_q    <= adc_data;
            s2_q    <= s1_q;
            wr_ev_q <= tick_s;
            if (tick_s) begin
                // A value still settling through the synchroniser is not taken.
                if (s1_q == s2_q) begin
                    cur_q <= s2_q;
                end
                prev_q <= cur_q;
            end
        end
    end

    assign cross_s   = is_crossing(prev_q, cur_q, trig_level);
    assign timeout_s = trig_mode && (cnt_q == CNT_W'(AUTO_TIMEOUT));

    // Capture state machine; one RAM write the clock after each tick.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wr_ptr_d      = wr_ptr_q;
        base_d        = base_q;
        frame_ready_d = frame_ready_q;
        triggered_d   = triggered_q;
        we_s          = 1'b0;
        if (rearm) begin
            state_d       = ST_PRE;
            cnt_d         = '0;
            wr_ptr_d      = '0;
            frame_ready_d = 1'b0;
            triggered_d   = 1'b0;
        end else if (wr_ev_q && (state_q != ST_DONE)) begin
            we_s     = 1'b1;
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            case (state_q)
                ST_PRE: begin
                    if (cnt_q == CNT_W'(PRETRIG - 1)) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (cross_s || timeout_s) begin
                        // Frame starts PRETRIG slots before the trigger sample.
                        base_d      = wr_ptr_q - DEPTH_LOG2'(PRETRIG);
                        triggered_d = cross_s;
                        cnt_d       = '0;
                        if (POST_N == 0) begin
                            state_d       = ST_DONE;
                            frame_ready_d = 1'b1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else if (cnt_q != CNT_W'(AUTO_TIMEOUT)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_POST: begin
                    if (cnt_q == CNT_W'(POST_N - 1)) begin
                        state_d       = ST_DONE;
                        frame_ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            we_s = 1'b0;
        end
    end

    // Capture state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_PRE;
            cnt_q         <= '0;
            wr_ptr_q      <= '0;
            base_q        <= '0;
            frame_ready_q <= 1'b0;
            triggered_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            base_q        <= base_d;
            frame_ready_q <= frame_ready_d;
            triggered_q   <= triggered_d;
        end
    end

    assign raddr_s = base_q + rd_addr;

    wave_dpram #(
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (we_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (cur_q),
        .raddr_i (raddr_s),
        .rdata_o (rd_data)
    );

    assign frame_ready = frame_ready_q;
    assign triggered   = triggered_q;

endmodule

// File: tb/tb_adc_wave_capture.sv
// Self-checking bench for adc_wave_capture. A reference model records the list
// of samples written since the last rearm/reset and derives the frozen frame
// from that list with the trigger rules (first crossing after PRETRIG writes,
// or the forced trigger after AUTO_TIMEOUT armed writes in auto mode).
module tb_adc_wave_capture;

    localparam int SD = 4, DL = 4, PT = 4, AT = 32, DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    adc_data = 8'h00, trig_level = 8'h80;
    logic          trig_mode = 1'b0, rearm = 1'b0;
    logic [DL-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          frame_ready, triggered;

    adc_wave_capture #(
        .SAMPLE_DIV(SD), .DEPTH_LOG2(DL), .PRETRIG(PT), .AUTO_TIMEOUT(AT)
    ) dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .trig_level(trig_level),
        .trig_mode(trig_mode), .rearm(rearm), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_ready(frame_ready), .triggered(triggered)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         ph = 0, ticks = 0;
    logic [7:0] h1, h2, m_cur, m_prev;
    bit         pend;
    logic [7:0] w_cur[$], w_prev[$];

    function automatic int m_k();
        for (int k = PT; k < w_cur.size(); k++) begin
            if ((w_prev[k] < trig_level && w_cur[k] >= trig_level) ||
                (trig_mode && (k - PT) == AT)) return k;
        end
        return -1;
    endfunction

    function automatic bit m_done();
        int k;
        k = m_k();
        return (k >= 0) && (w_cur.size() >= k + DEPTH - PT);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                ph = 0; h1 = 8'h00; h2 = 8'h00; m_cur = 8'h00; m_prev = 8'h00; pend = 0;
                w_cur.delete(); w_prev.delete();
            end else begin
                if (rearm) begin
                    w_cur.delete(); w_prev.delete();
                end else if (pend && !m_done()) begin
                    w_cur.push_back(m_cur); w_prev.push_back(m_prev);
                end
                pend = 0;
                if (ph == SD - 1) begin
                    ph = 0; ticks++;
                    m_prev = m_cur;
                    if (h1 == h2) m_cur = h1;
                    pend = 1;
                end else begin
                    ph++;
                end
                h2 = h1; h1 = adc_data;
            end
        end
    end

    // frame_ready must track the model on every clock.
    initial begin
        forever begin
            @(posedge clk); #1;
            check_eq("frame_ready_live", frame_ready, m_done());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ticks(input int n);
        int t0, guard;
        t0 = ticks; guard = 0;
        while (ticks < t0 + n && guard < n * SD + 8) begin
            @(negedge clk); guard++;
        end
        if (ticks < t0 + n) check_eq("tick_timeout", ticks, t0 + n);
    endtask

    task automatic slot(input logic [7:0] v);
        adc_data = v; wait_ticks(1);
    endtask

    task automatic feed_until_done(input logic [7:0] v, input int max);
        for (int j = 0; j < max && !m_done(); j++) slot(v);
    endtask

    task automatic pulse_rearm(input logic [7:0] lvl, input logic mode);
        trig_level = lvl; trig_mode = mode; rearm = 1'b1;
        @(negedge clk); rearm = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [7:0] exp);
        rd_addr = DL'(a); @(negedge clk);
        check_eq(tag, rd_data, exp);
    endtask

    task automatic verify_frame(input string tag);
        int k;
        k = m_k();
        check_eq({tag, "_ready"}, frame_ready, 1);
        if (k < 0 || w_cur.size() < k + DEPTH - PT) begin
            check_eq({tag, "_no_frame"}, w_cur.size(), k + DEPTH - PT);
        end else begin
            check_eq({tag, "_trig"}, triggered,
                     (w_prev[k] < trig_level) && (w_cur[k] >= trig_level));
            rd_addr = '0;
            for (int i = 0; i < DEPTH; i++) begin
                @(negedge clk);
                check_eq($sformatf("%s_rd%0d", tag, i), rd_data, w_cur[k - PT + i]);
                rd_addr = DL'(i + 1);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_rd_data", rd_data, 8'h00);
        check_eq("rst_frame_ready", frame_ready, 1'b0);
        check_eq("rst_triggered", triggered, 1'b0);
        rst = 1'b0;

        // Ramp, normal mode, level 0x80.
        for (int j = 0; j < 200 && !m_done(); j++) slot(8'(j));
        verify_frame("ramp");
        rd_chk("ramp_a0", 0, 8'h7C);
        rd_chk("ramp_a4", 4, 8'h80);
        rd_chk("ramp_a15", 15, 8'h8B);
        check_eq("ramp_triggered", triggered, 1'b1);

        // Rearm in DONE, then constant input in auto mode.
        pulse_rearm(8'h80, 1'b1);
        check_eq("rearm_drop", frame_ready, 1'b0);
        feed_until_done(8'h10, 100);
        verify_frame("auto");
        check_eq("auto_triggered", triggered, 1'b0);
        rd_chk("auto_a9", 9, 8'h10);

        // Constant input, normal mode: never completes.
        pulse_rearm(8'h80, 1'b0);
        for (int j = 0; j < 200; j++) slot(8'h10);
        check_eq("normal_idle", frame_ready, 1'b0);

        // Trigger at wr_ptr 2 -> frame wraps around the buffer end.
        trig_level = 8'h80; trig_mode = 1'b0;
        do_reset();
        for (int j = 0; j < 18; j++) slot(8'h20);
        feed_until_done(8'h90, 40);
        verify_frame("wrap");
        rd_chk("wrap_a3", 3, 8'h20);
        rd_chk("wrap_a4", 4, 8'h90);

        // Glitches caught mid-synchroniser must not be stored or trigger.
        pulse_rearm(8'h80, 1'b0);
        for (int j = 0; j < 8; j++) slot(8'h10);
        for (int g = 0; g < 3; g++) begin
            for (int guard = 0; guard < 2 * SD && ph != 2; guard++) @(negedge clk);
            adc_data = 8'hF0; @(negedge clk);
            adc_data = 8'h10; wait_ticks(1);
        end
        feed_until_done(8'h90, 40);
        verify_frame("glitch");
        rd_chk("glitch_a3", 3, 8'h10);
        rd_chk("glitch_a4", 4, 8'h90);

        // Rearm during POST restarts the capture.
        pulse_rearm(8'h80, 1'b0);
        for (int j = 0; j < 6; j++) slot(8'h20);
        for (int j = 0; j < 3; j++) slot(8'h90);
        check_eq("post_not_ready", frame_ready, 1'b0);
        pulse_rearm(8'h80, 1'b0);
        for (int j = 0; j < 6; j++) slot(8'h20);
        feed_until_done(8'h95, 40);
        verify_frame("postrearm");
        rd_chk("postrearm_a0", 0, 8'h20);
        rd_chk("postrearm_a4", 4, 8'h95);

        // Asynchronous reset mid-POST.
        pulse_rearm(8'h80, 1'b0);
        for (int j = 0; j < 6; j++) slot(8'h20);
        for (int j = 0; j < 3; j++) slot(8'h90);
        rd_chk("post_rd_trig", 4, 8'h90);
        check_eq("post_triggered", triggered, 1'b1);
        rst = 1'b1; #1;
        check_eq("arst_rd_data", rd_data, 8'h00);
        check_eq("arst_frame_ready", frame_ready, 1'b0);
        check_eq("arst_triggered", triggered, 1'b0);
        trig_level = 8'hFF; trig_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Level 0xFF is reached only by 0xFF itself.
        for (int j = 0; j < 15; j++) slot(8'hF0 + 8'(j));
        feed_until_done(8'hFF, 30);
        verify_frame("lvlff");
        rd_chk("lvlff_a3", 3, 8'hFE);
        rd_chk("lvlff_a4", 4, 8'hFF);

        // Level 0x00 never crosses.
        pulse_rearm(8'h00, 1'b0);
        for (int j = 0; j < 60; j++) slot(8'($urandom_range(0, 255)));
        check_eq("lvl0_idle", frame_ready, 1'b0);

        // Randomised captures.
        for (int r = 0; r < 5; r++) begin
            pulse_rearm(8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
            for (int j = 0; j < 120 && !m_done(); j++) slot(8'($urandom_range(0, 255)));
            if (m_done()) verify_frame($sformatf("rand%0d", r));
            else check_eq("rand_idle", frame_ready, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
